irq_controller: RTL
===================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of interrupt sources; index 0 is highest priority.
REQ-002 SHALL have parameter ID_W, default 2: width of irq_id; 2**ID_W >= NUM_SRC.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port clrn, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port src_irq, input, NUM_SRC: raw source lines; the timer device's irq_pin is on bit 0.
REQ-006 SHALL have port global_int_en, input, 1: CPU global interrupt enable.
REQ-007 SHALL have port mask_we, input, 1: mask register write strobe.
REQ-008 SHALL have port mask_wdata, input, NUM_SRC: mask write data; bit 1 enables the source.
REQ-009 SHALL have port cpu_ack, input, 1: CPU accepts the current request.
REQ-010 SHALL have port eoi, input, 1: CPU end-of-interrupt.
REQ-011 SHALL have port cpu_irq, output, 1: registered interrupt request to the CPU.
REQ-012 SHALL have port irq_id, output, ID_W: index of the requested or in-service source.
REQ-013 SHALL have port in_service, output, 1: high while the CPU is handling an interrupt.
REQ-014 SHALL have ports mask and pending, outputs, NUM_SRC: current register contents.

Function
REQ-015 SHALL latch pending[i] <= 1 on a rising edge of src_irq[i] (src_irq[i] high, src_q[i] low), regardless of mask.
REQ-016 SHALL define eligible = pending & mask; masked pending bits are held and become eligible once unmasked.
REQ-017 SHALL implement FSM states IDLE, REQ, SERVICE with these transitions:
- IDLE -> REQ when global_int_en && |eligible; irq_id <= lowest eligible index.
- REQ -> SERVICE on cpu_ack; pending[irq_id] clears on the same edge.
- REQ -> IDLE if global_int_en is low and cpu_ack is low; pending is kept.
- SERVICE -> IDLE on eoi.
REQ-018 SHALL drive cpu_irq = (state==REQ) and in_service = (state==SERVICE), both from registers.
REQ-019 SHALL give 2-cycle latency: a source rising at edge N raises cpu_irq after edge N+1.
REQ-020 SHALL hold irq_id stable through REQ and SERVICE; a higher-priority arrival does not preempt.
REQ-021 SHALL keep pending[irq_id] set when its rising edge coincides with the ack clear (set wins).
REQ-022 SHALL update mask <= mask_wdata on mask_we, effective for arbitration on the next cycle; masking the id already in REQ does not withdraw the request.
REQ-023 SHALL ignore cpu_ack outside REQ and eoi outside SERVICE.
REQ-024 SHALL spend at least one cycle in IDLE between SERVICE and the next REQ.

Reset
REQ-025 SHALL, on clrn low at a clock edge, set state=IDLE, cpu_irq=0, in_service=0, irq_id=0, pending=0, mask=0 (all disabled), and src_q to all ones so that lines held high through reset do not trigger.
REQ-026 SHALL let reset abort REQ or SERVICE immediately with no pending retained.

Configuration
REQ-027 SHALL use macro IRQ_CTRL_EDGE_EN to select edge or level behaviour:
- Defined: edge-latched pending per REQ-015 and REQ-021.
- Undefined: pending = src_irq (level, unlatched), no src_q, and ack clears nothing; the source must drop its line before eoi, otherwise it re-requests after IDLE.

Structure
REQ-028 SHALL place in shared define.v the state encodings (IRQ_ST_IDLE/REQ/SERVICE), the default NUM_SRC/ID_W, and source index constants (IRQ_SRC_TIMER=0, IRQ_SRC_KBD=1).
REQ-029 SHALL implement lowest-index selection in one combinational sub-module irq_prio_enc (inputs: eligible; outputs: id and valid).

Verification
REQ-030 SHALL have a bench cover each scenario below (stimulus -> required response):
- Reset, mask=4'b0001, src_irq[0] pulses 1 cycle at edge 10 -> pending=0001 at 10, cpu_irq=1 and irq_id=0 after edge 11.
- mask=4'b1111, src 2 and src 1 rise together -> irq_id=1; after ack and eoi a second request with irq_id=2; pending=0 at the end.
- mask=0, src 3 rises; 20 cycles later write mask=1000 -> cpu_irq rises 2 edges after the write.
- global_int_en=0 while src 0 pending -> cpu_irq stays 0; drop global_int_en during REQ -> IDLE with pending[0]=1.
- src 0 rises on the same edge as cpu_ack for id 0 -> pending[0] stays 1 and re-requests after eoi plus 1 IDLE cycle.
- clrn low during SERVICE -> next edge all outputs 0; src_irq held high across reset produces no request.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// rtl/irq_controller_pkg.sv - shared state encodings, default sizes and source indices
package irq_controller_pkg;

  typedef enum logic [1:0] {
    IRQ_ST_IDLE    = 2'd0,
    IRQ_ST_REQ     = 2'd1,
    IRQ_ST_SERVICE = 2'd2
  } irq_state_e;

  localparam int IRQ_NUM_SRC_DEF = 4;
  localparam int IRQ_ID_W_DEF    = 2;

  localparam int IRQ_SRC_TIMER = 0;
  localparam int IRQ_SRC_KBD   = 1;

endpackage

// File: rtl/irq_controller_prio.sv
// rtl/irq_controller_prio.sv - lowest-index-wins priority encoder (irq_prio_enc)
module irq_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] eligible,
  output logic [ID_W-1:0]    id,
  output logic               valid
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - prioritised interrupt controller with mask and IDLE/REQ/SERVICE handshake
// IRQ_CTRL_EDGE_EN defined: edge-latched pending; undefined: pending samples the level each cycle.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NUM_SRC = IRQ_NUM_SRC_DEF,
  parameter int ID_W    = IRQ_ID_W_DEF
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               global_int_en,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               cpu_ack,
  input  logic               eoi,
  output logic               cpu_irq,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending
);

  irq_state_e         state;
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    win_id;
  logic               win_valid;

  assign eligible = pending & mask;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .eligible (eligible),
    .id       (win_id),
    .valid    (win_valid)
  );

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] ack_clr;

  assign ack_clr = (state == IRQ_ST_REQ && cpu_ack) ? (NUM_SRC'(1) << irq_id) : '0;

  // src_q resets high so lines already asserted through reset are not seen as edges.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      src_q   <= '1;
      pending <= '0;
    end else begin
      src_q   <= src_irq;
      pending <= (pending & ~ack_clr) | (src_irq & ~src_q);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!clrn) begin
      pending <= '0;
    end else begin
      pending <= src_irq;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!clrn) begin
      mask <= '0;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state      <= IRQ_ST_IDLE;
      cpu_irq    <= 1'b0;
      in_service <= 1'b0;
      irq_id     <= '0;
    end else begin
      case (state)
        IRQ_ST_IDLE: begin
          if (global_int_en && win_valid) begin
            state   <= IRQ_ST_REQ;
            cpu_irq <= 1'b1;
            irq_id  <= win_id;
          end
        end
        // Once raised, only ack or loss of global enable ends the request.
        IRQ_ST_REQ: begin
          if (cpu_ack) begin
            state      <= IRQ_ST_SERVICE;
            cpu_irq    <= 1'b0;
            in_service <= 1'b1;
          end else if (!global_int_en) begin
            state   <= IRQ_ST_IDLE;
            cpu_irq <= 1'b0;
          end
        end
        IRQ_ST_SERVICE: begin
          if (eoi) begin
            state      <= IRQ_ST_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IRQ_ST_IDLE;
          cpu_irq    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule
